// File: rtl/mcode_seq_pkg.sv
// Shared definitions for the microcode sequencer: address/counter widths,
// sequencing-field encodings and the sequencer state enum.
package mcode_pkg;

    localparam int unsigned MC_ADDR_W = 6;
    localparam int unsigned MC_CNT_W  = 6;
    localparam int unsigned SEQ_OP_W  = 3;

    // Sequencing field of a microword
    typedef enum logic [SEQ_OP_W-1:0] {
        SEQ_NEXT   = 3'd0,
        SEQ_JUMP   = 3'd1,
        SEQ_BRANCH = 3'd2,
        SEQ_CALL   = 3'd3,
        SEQ_RET    = 3'd4,
        SEQ_LOOP   = 3'd5,
        SEQ_WAIT   = 3'd6,
        SEQ_END    = 3'd7
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WAIT  = 2'd3
    } mc_state_e;

endpackage

// File: rtl/mcode_seq_if.sv
// Sequencer bus: start/dispatch, microword fields returned by the ROM,
// loop-count load, wait release, and the address/status outputs.
//   master : the sequencer (drives a, exec, busy, done)
//   slave  : the parent/ROM side (drives everything else)
interface mcode_seq_if #(
    parameter int unsigned ENTRY_W = mcode_pkg::MC_ADDR_W,
    parameter int unsigned CNT_W   = mcode_pkg::MC_CNT_W
);
    import mcode_pkg::*;

    logic                start;
    logic [ENTRY_W-1:0]  entry;
    logic [SEQ_OP_W-1:0] seq_op;
    logic [ENTRY_W-1:0]  seq_tgt;
    logic                cond;
    logic                ld_cnt;
    logic [CNT_W-1:0]    cnt_in;
    logic                ack;
    logic [ENTRY_W-1:0]  a;
    logic                exec;
    logic                busy;
    logic                done;

    modport master (
        input  start, entry, seq_op, seq_tgt, cond, ld_cnt, cnt_in, ack,
        output a, exec, busy, done
    );

    modport slave (
        output start, entry, seq_op, seq_tgt, cond, ld_cnt, cnt_in, ack,
        input  a, exec, busy, done
    );

endinterface

// File: rtl/mcode_seq_nextaddr.sv
// Combinational next-address, return-register and loop-counter mux.
// Inputs: current state, microword fields, cond/ack/start/entry, ld_cnt/cnt_in
// and the current registered values. Outputs: next values for each register.
module mcode_nextaddr
    import mcode_pkg::*;
#(
    parameter int unsigned ADDR_W = MC_ADDR_W,
    parameter int unsigned CNT_W  = MC_CNT_W
) (
    input  mc_state_e          state,
    input  seq_op_e            op,
    input  logic [ADDR_W-1:0]  seq_tgt,
    input  logic               cond,
    input  logic               ack,
    input  logic               start,
    input  logic [ADDR_W-1:0]  entry,
    input  logic               ld_cnt,
    input  logic [CNT_W-1:0]   cnt_in,
    input  logic [ADDR_W-1:0]  a,
    input  logic               ret_vld,
    input  logic [ADDR_W-1:0]  ret_a,
    input  logic [CNT_W-1:0]   cnt,
    output logic [ADDR_W-1:0]  a_nxt,
    output logic               ret_vld_nxt,
    output logic [ADDR_W-1:0]  ret_a_nxt,
    output logic [CNT_W-1:0]   cnt_nxt
);

    logic [ADDR_W-1:0] a_inc;

    // Wraps naturally at the address width
    assign a_inc = a + ADDR_W'(1);

    // A load always wins; a LOOP still decides on the pre-load count
    always_comb begin
        a_nxt       = a;
        ret_vld_nxt = ret_vld;
        ret_a_nxt   = ret_a;
        cnt_nxt     = ld_cnt ? cnt_in : cnt;
        case (state)
            ST_IDLE: begin
                if (start) a_nxt = entry;
            end
            ST_EXEC: begin
                case (op)
                    SEQ_NEXT:   a_nxt = a_inc;
                    SEQ_JUMP:   a_nxt = seq_tgt;
                    SEQ_BRANCH: a_nxt = cond ? seq_tgt : a_inc;
                    SEQ_CALL: begin
                        ret_vld_nxt = 1'b1;
                        ret_a_nxt   = a_inc;
                        a_nxt       = seq_tgt;
                    end
                    SEQ_RET: begin
                        // Invalid return register: acts as END, address held
                        if (ret_vld) begin
                            a_nxt       = ret_a;
                            ret_vld_nxt = 1'b0;
                        end
                    end
                    SEQ_LOOP: begin
                        if (cnt != '0) begin
                            a_nxt = seq_tgt;
                            if (!ld_cnt) cnt_nxt = cnt - CNT_W'(1);
                        end else begin
                            a_nxt = a_inc;
                        end
                    end
                    SEQ_WAIT: begin
                        if (ack) a_nxt = a_inc;
                    end
                    default: ;
                endcase
            end
            ST_WAIT: begin
                if (ack) a_nxt = a_inc;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcode_seq.sv
// Microcode sequencer: drives the registered ROM address and interprets the
// sequencing field of each returned microword.
// Ports: sys_clk, reset (async, active high), bus (mcode_seq_if.master):
//   start/entry dispatch, seq_op/seq_tgt from the ROM, cond, ld_cnt/cnt_in,
//   ack; outputs a (registered), exec, busy, done (state decodes).
module mcode_seq
    import mcode_pkg::*;
#(
    parameter int unsigned ENTRY_W = MC_ADDR_W,
    parameter int unsigned CNT_W   = MC_CNT_W
) (
    input  logic          sys_clk,
    input  logic          reset,
    mcode_seq_if.master   bus
);

    mc_state_e           state, state_nxt;
    logic [ENTRY_W-1:0]  a_q, a_nxt;
    logic [ENTRY_W-1:0]  ret_a_q, ret_a_nxt;
    logic                ret_vld_q, ret_vld_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    seq_op_e             op;
    logic                exec_c, busy_c, done_c;

    assign op = seq_op_e'(bus.seq_op);

    mcode_nextaddr #(
        .ADDR_W (ENTRY_W),
        .CNT_W  (CNT_W)
    ) u_nextaddr (
        .state       (state),
        .op          (op),
        .seq_tgt     (bus.seq_tgt),
        .cond        (bus.cond),
        .ack         (bus.ack),
        .start       (bus.start),
        .entry       (bus.entry),
        .ld_cnt      (bus.ld_cnt),
        .cnt_in      (bus.cnt_in),
        .a           (a_q),
        .ret_vld     (ret_vld_q),
        .ret_a       (ret_a_q),
        .cnt         (cnt_q),
        .a_nxt       (a_nxt),
        .ret_vld_nxt (ret_vld_nxt),
        .ret_a_nxt   (ret_a_nxt),
        .cnt_nxt     (cnt_nxt)
    );

    // State, address, return register and loop counter
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            ret_vld_q <= 1'b0;
            ret_a_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            a_q       <= a_nxt;
            ret_vld_q <= ret_vld_nxt;
            ret_a_q   <= ret_a_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    // Next state and status decode
    always_comb begin
        state_nxt = state;
        exec_c    = 1'b0;
        done_c    = 1'b0;
        busy_c    = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_FETCH;
            end
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC: begin
                exec_c = 1'b1;
                case (op)
                    SEQ_WAIT: state_nxt = bus.ack ? ST_FETCH : ST_WAIT;
                    SEQ_END: begin
                        state_nxt = ST_IDLE;
                        done_c    = 1'b1;
                    end
                    SEQ_RET: begin
                        if (ret_vld_q) begin
                            state_nxt = ST_FETCH;
                        end else begin
                            state_nxt = ST_IDLE;
                            done_c    = 1'b1;
                        end
                    end
                    default: state_nxt = ST_FETCH;
                endcase
            end
            ST_WAIT: begin
                if (bus.ack) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.a    = a_q;
    assign bus.exec = exec_c;
    assign bus.busy = busy_c;
    assign bus.done = done_c;

endmodule
